// File: rtl/ex_stage_pkg.sv
// Shared widths, bundle layout, ALU op indices and divider state encoding
// for the LoongArch execute stage.
package ex_stage_pkg;

    localparam int to_EX_data_width  = 162;
    localparam int to_MEM_data_width = 74;
    localparam int forwrd_data_width = 38;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_SLT   = 2;
    localparam int OP_SLTU  = 3;
    localparam int OP_AND   = 4;
    localparam int OP_NOR   = 5;
    localparam int OP_OR    = 6;
    localparam int OP_XOR   = 7;
    localparam int OP_SLL   = 8;
    localparam int OP_SRL   = 9;
    localparam int OP_SRA   = 10;
    localparam int OP_LUI   = 11;
    localparam int OP_MUL   = 12;
    localparam int OP_MULH  = 13;
    localparam int OP_MULHU = 14;
    localparam int OP_DIV   = 15;
    localparam int OP_MOD   = 16;
    localparam int OP_DIVU  = 17;
    localparam int OP_MODU  = 18;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rj_value;
        logic [31:0] rkd_value;
        logic [31:0] imm;
        logic [18:0] alu_op;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        rd1B;
        logic        rd2B;
        logic        rd4B;
        logic        rd_signed;
        logic        wr1B;
        logic        wr2B;
        logic        wr4B;
        logic [4:0]  dest;
        logic        gr_we;
    } ex_bundle_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Byte lanes of a store; the word is little-endian and alignment is not checked.
    function automatic logic [3:0] store_we(input logic wr1, input logic wr2,
                                            input logic wr4, input logic [1:0] a);
        logic [3:0] we;
        if (wr1) begin
            we = 4'b0001 << a;
        end else if (wr2) begin
            we = 4'b0011 << {a[1], 1'b0};
        end else if (wr4) begin
            we = 4'b1111;
        end else begin
            we = 4'b0000;
        end
        return we;
    endfunction

endpackage

// File: rtl/ex_divider.sv
// Iterative 32-bit restoring divider: magnitudes plus sign flags are latched,
// one quotient bit is produced per cycle, and the result is held until acked.
module ex_divider
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;
    logic [32:0] shifted_s, diff_s;

    // Next-state and datapath for the shift-subtract iterations.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dz_d      = dz_q;
        shifted_s = {rem_q, quo_q[31]};
        diff_s    = shifted_s - {1'b0, dvs_q};
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_BUSY;
                    cnt_d   = 5'd0;
                    quo_d   = (signed_op && a[31]) ? (32'd0 - a) : a;
                    rem_d   = 32'd0;
                    dvs_d   = (signed_op && b[31]) ? (32'd0 - b) : b;
                    q_neg_d = signed_op & (a[31] ^ b[31]);
                    r_neg_d = signed_op & a[31];
                    dz_d    = (b == 32'd0);
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                cnt_d = cnt_q + 5'd1;
                if (!diff_s[32]) begin
                    rem_d = diff_s[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted_s[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd31) begin
                    state_d = DIV_DONE;
                end else begin
                    state_d = DIV_BUSY;
                end
            end
            DIV_DONE: begin
                if (ack) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_DONE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= 5'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvs_q   <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    // Divide-by-zero leaves the dividend in the remainder, so only the quotient needs overriding.
    assign busy      = (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE);
    assign quotient  = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (32'd0 - quo_q) : quo_q);
    assign remainder = r_neg_q ? (32'd0 - rem_q) : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, single-cycle ALU/multiply, iterative divide,
// data-SRAM request generation and the forwarding bundle for decode.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         ID_to_EX_valid,
    input  logic [to_EX_data_width-1:0]  to_EX_data,
    output logic                         EX_allow_in,
    input  logic                         MEM_allow_in,
    output logic                         EX_to_MEM_valid,
    output logic [to_MEM_data_width-1:0] to_MEM_data,
    output logic [forwrd_data_width-1:0] EX_forward,
    output logic                         data_sram_en,
    output logic [3:0]                   data_sram_we,
    output logic [31:0]                  data_sram_addr,
    output logic [31:0]                  data_sram_wdata
);

    ex_bundle_t  bundle_q, bundle_d;
    logic        ex_valid_q, ex_valid_d;
    logic [31:0] src1_s, src2_s, result_s, quo_s, rem_s;
    logic [18:0] op_s;
    logic [63:0] mul_a_s, mul_b_s, prod_s;
    logic        is_div_s, ready_go_s, mem_op_s, div_busy_s, div_done_s;

    // Input register load control.
    always_comb begin
        ex_valid_d = ex_valid_q;
        bundle_d   = bundle_q;
        if (EX_allow_in) begin
            ex_valid_d = ID_to_EX_valid;
            if (ID_to_EX_valid) begin
                bundle_d = ex_bundle_t'(to_EX_data);
            end else begin
                bundle_d = bundle_q;
            end
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // Stage valid and bundle registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid_q <= 1'b0;
            bundle_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            bundle_q   <= bundle_d;
        end
    end

    assign op_s     = bundle_q.alu_op;
    assign src1_s   = bundle_q.src1_is_pc  ? bundle_q.pc  : bundle_q.rj_value;
    assign src2_s   = bundle_q.src2_is_imm ? bundle_q.imm : bundle_q.rkd_value;
    assign is_div_s = |op_s[OP_MODU:OP_DIV];

    // Low 64 bits of a product of sign- or zero-extended operands serve mul, mulh and mulhu alike.
    assign mul_a_s = {{32{op_s[OP_MULH] & src1_s[31]}}, src1_s};
    assign mul_b_s = {{32{op_s[OP_MULH] & src2_s[31]}}, src2_s};
    assign prod_s  = mul_a_s * mul_b_s;

    ex_divider u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (ex_valid_q & is_div_s & ~div_busy_s & ~div_done_s),
        .signed_op (op_s[OP_DIV] | op_s[OP_MOD]),
        .a         (src1_s),
        .b         (src2_s),
        .ack       (MEM_allow_in),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quotient  (quo_s),
        .remainder (rem_s)
    );

    assign result_s = ({32{op_s[OP_ADD]}}   & (src1_s + src2_s))
                    | ({32{op_s[OP_SUB]}}   & (src1_s - src2_s))
                    | ({32{op_s[OP_SLT]}}   & {31'd0, $signed(src1_s) < $signed(src2_s)})
                    | ({32{op_s[OP_SLTU]}}  & {31'd0, src1_s < src2_s})
                    | ({32{op_s[OP_AND]}}   & (src1_s & src2_s))
                    | ({32{op_s[OP_NOR]}}   & ~(src1_s | src2_s))
                    | ({32{op_s[OP_OR]}}    & (src1_s | src2_s))
                    | ({32{op_s[OP_XOR]}}   & (src1_s ^ src2_s))
                    | ({32{op_s[OP_SLL]}}   & (src1_s << src2_s[4:0]))
                    | ({32{op_s[OP_SRL]}}   & (src1_s >> src2_s[4:0]))
                    | ({32{op_s[OP_SRA]}}   & 32'($signed(src1_s) >>> src2_s[4:0]))
                    | ({32{op_s[OP_LUI]}}   & src2_s)
                    | ({32{op_s[OP_MUL]}}   & prod_s[31:0])
                    | ({32{op_s[OP_MULH] | op_s[OP_MULHU]}} & prod_s[63:32])
                    | ({32{op_s[OP_DIV]  | op_s[OP_DIVU]}}  & quo_s)
                    | ({32{op_s[OP_MOD]  | op_s[OP_MODU]}}  & rem_s);

    assign ready_go_s      = ~is_div_s | div_done_s;
    assign EX_allow_in     = ~ex_valid_q | (ready_go_s & MEM_allow_in);
    assign EX_to_MEM_valid = ex_valid_q & ready_go_s;

    // Requests only on the handoff cycle, so each load or store fires exactly once.
    assign mem_op_s        = bundle_q.rd1B | bundle_q.rd2B | bundle_q.rd4B
                           | bundle_q.wr1B | bundle_q.wr2B | bundle_q.wr4B;
    assign data_sram_en    = ex_valid_q & ready_go_s & MEM_allow_in & mem_op_s;
    assign data_sram_we    = data_sram_en ? store_we(bundle_q.wr1B, bundle_q.wr2B,
                                                     bundle_q.wr4B, result_s[1:0]) : 4'b0000;
    assign data_sram_addr  = result_s;
    assign data_sram_wdata = bundle_q.wr1B ? {4{bundle_q.rkd_value[7:0]}}  :
                             bundle_q.wr2B ? {2{bundle_q.rkd_value[15:0]}} :
                                             bundle_q.rkd_value;

    assign to_MEM_data = {bundle_q.pc, result_s, bundle_q.rd1B, bundle_q.rd2B, bundle_q.rd4B,
                          bundle_q.rd_signed, bundle_q.dest, bundle_q.gr_we};

    assign EX_forward  = {bundle_q.dest & {5{ex_valid_q & bundle_q.gr_we}}, result_s,
                          ex_valid_q & (bundle_q.rd1B | bundle_q.rd2B | bundle_q.rd4B
                                        | (is_div_s & ~div_done_s))};

endmodule
